// File: rtl/sipo_frame_controller.sv
// rtl/sipo_frame_controller.sv - framed serial-in/parallel-out capture with valid/ready word output (optional PARITY_CHECK_EN)
module sipo_frame_controller #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         bit_valid,
    input  logic                         serial_in,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count,
    output logic                         overrun,
    input  logic                         clear_overrun,
    output logic                         parity_err
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_HOLD   = 2'd2
`ifdef PARITY_CHECK_EN
        , S_PARITY = 2'd3
`endif
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sr, sr_n;
    logic [WIDTH-1:0]  data_n;
    logic [CW-1:0]     cnt_n;
    logic              ovr_n;
    logic              perr_q, perr_n;
    logic [WIDTH-1:0]  shifted;

    assign shifted   = {sr[WIDTH-2:0], serial_in};
    // Outputs decode only registered state, so out_ready never reaches out_valid/out_data combinationally
    assign out_valid = (state == S_HOLD);
`ifdef PARITY_CHECK_EN
    assign busy       = (state == S_SHIFT) || (state == S_PARITY);
    assign parity_err = perr_q;
`else
    assign busy       = (state == S_SHIFT);
    assign parity_err = 1'b0;
`endif

    // Next-state and datapath update: framing, bit capture, hold/handshake and overrun tracking
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = bit_count;
        data_n  = out_data;
        perr_n  = perr_q;
        ovr_n   = overrun;
        // Clear first so any set below takes priority in the same cycle
        if (clear_overrun) begin
            ovr_n = 1'b0;
        end
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                    sr_n    = '0;
                end
            end
            S_SHIFT: begin
                if (start) begin
                    // Abort the partial frame and restart in place; a same-cycle bit is ignored
                    cnt_n = '0;
                    sr_n  = '0;
                end else if (bit_valid) begin
                    sr_n  = shifted;
                    cnt_n = bit_count + CW'(1);
                    if (bit_count == CW'(WIDTH-1)) begin
                        data_n = shifted;
`ifdef PARITY_CHECK_EN
                        state_n = S_PARITY;
`else
                        state_n = S_HOLD;
                        perr_n  = 1'b0;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (start) begin
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                    sr_n    = '0;
                end else if (bit_valid) begin
                    // Even parity: data bits plus parity bit must XOR to zero
                    perr_n  = (^sr) ^ serial_in;
                    state_n = S_HOLD;
                end
            end
`endif
            S_HOLD: begin
                if (out_ready) begin
                    cnt_n = '0;
                    if (start) begin
                        state_n = S_SHIFT;
                        sr_n    = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (start) begin
                    ovr_n = 1'b1;
                end
                // A bit arriving while the word is parked is lost, unless a restart claims the cycle
                if (bit_valid && !(start && out_ready)) begin
                    ovr_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sr        <= '0;
            out_data  <= '0;
            bit_count <= '0;
            overrun   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            out_data  <= data_n;
            bit_count <= cnt_n;
            overrun   <= ovr_n;
            perr_q    <= perr_n;
        end
    end

endmodule
